// File: rtl/gpioemu_pkg.sv
// rtl/gpioemu_pkg.sv - shared status codes, FSM states and default bus addresses for the prime peripheral
package gpioemu_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIV_RUN,
      EVAL,
      NEXT,
      DONE,
      ERR
   } state_e;

   localparam logic [15:0] ADDR_A_DEF = 16'h0224;
   localparam logic [15:0] ADDR_W_DEF = 16'h0234;
   localparam logic [15:0] ADDR_P_DEF = 16'h0238;
   localparam logic [15:0] ADDR_S_DEF = 16'h023C;

endpackage

// File: rtl/prime_rem_div.sv
// rtl/prime_rem_div.sv - sequential restoring divider returning only the remainder, start/done handshake
module prime_rem_div #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              abort,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] rem
);

   localparam int CW = $clog2(DATA_W + 1);

   logic              run_q, run_d;
   logic              done_q, done_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic [DATA_W-1:0] dsr_q, dsr_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W:0]   trial;

   always_comb begin
      run_d  = run_q;
      done_d = 1'b0;
      cnt_d  = cnt_q;
      dvd_d  = dvd_q;
      dsr_d  = dsr_q;
      rem_d  = rem_q;
      trial  = {rem_q, dvd_q[DATA_W-1]};
      if (abort) begin
         run_d = 1'b0;
      end else if (!run_q) begin
         if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            dvd_d = dividend;
            dsr_d = divisor;
            rem_d = '0;
         end
      end else begin
         // partial remainder stays below the divisor, so the subtracted value fits DATA_W bits
         if (trial >= {1'b0, dsr_q}) begin
            rem_d = DATA_W'(trial - {1'b0, dsr_q});
         end else begin
            rem_d = trial[DATA_W-1:0];
         end
         dvd_d = dvd_q << 1;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(DATA_W - 1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q  <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         dvd_q  <= '0;
         dsr_q  <= '0;
         rem_q  <= '0;
      end else begin
         run_q  <= run_d;
         done_q <= done_d;
         cnt_q  <= cnt_d;
         dvd_q  <= dvd_d;
         dsr_q  <= dsr_d;
         rem_q  <= rem_d;
      end
   end

   assign done = done_q;
   assign rem  = rem_q;

endmodule

// File: rtl/gpioemu_prime_seq.sv
// rtl/gpioemu_prime_seq.sv - bus peripheral computing the A-th prime by trial division; GPIOEMU_PRIME_PROGRESS_EN exposes found at ADDR_P
module gpioemu_prime_seq
   import gpioemu_pkg::*;
#(
   parameter int          DATA_W = 32,
   parameter logic [15:0] ADDR_A = ADDR_A_DEF,
   parameter logic [15:0] ADDR_W = ADDR_W_DEF,
   parameter logic [15:0] ADDR_S = ADDR_S_DEF
`ifdef GPIOEMU_PRIME_PROGRESS_EN
   ,
   parameter logic [15:0] ADDR_P = ADDR_P_DEF
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       saddress,
   input  logic              srd,
   input  logic              swr,
   input  logic [DATA_W-1:0] sdata_in,
   output logic [DATA_W-1:0] sdata_out,
   output logic [31:0]       gpio_out,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] w_q, w_d;
   logic [1:0]        s_q, s_d;
   logic [15:0]       done_cnt_q, done_cnt_d;
   logic [DATA_W-1:0] cand_q, cand_d;
   logic [DATA_W-1:0] div_q, div_d;
   logic [DATA_W-1:0] found_q, found_d;
   logic              start_q, start_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;

   logic                wr_a;
   logic                div_done;
   logic [DATA_W-1:0]   div_rem;
   logic [2*DATA_W-1:0] div_sq;
   logic [2*DATA_W-1:0] cand_w;

   assign wr_a   = swr && (saddress == ADDR_A);
   assign div_sq = {{DATA_W{1'b0}}, div_q} * {{DATA_W{1'b0}}, div_q};
   assign cand_w = {{DATA_W{1'b0}}, cand_q};

   prime_rem_div #(.DATA_W(DATA_W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .abort    (wr_a),
      .start    (start_q),
      .dividend (cand_q),
      .divisor  (div_q),
      .done     (div_done),
      .rem      (div_rem)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      w_d        = w_q;
      s_d        = s_q;
      done_cnt_d = done_cnt_q;
      cand_d     = cand_q;
      div_d      = div_q;
      found_d    = found_q;
      start_d    = 1'b0;
      sdata_d    = sdata_q;

      case (state_q)
         IDLE: ;
         CHECK: begin
            if (div_sq > cand_w) begin
               state_d = EVAL;
            end else begin
               start_d = 1'b1;
               state_d = DIV_RUN;
            end
         end
         DIV_RUN: begin
            if (div_done) begin
               if (div_rem == '0) begin
                  state_d = NEXT;
               end else begin
                  div_d   = div_q + DATA_W'(1);
                  state_d = CHECK;
               end
            end
         end
         EVAL: begin
            found_d = found_q + DATA_W'(1);
            if (found_q + DATA_W'(1) == a_q) begin
               w_d     = cand_q;
               state_d = DONE;
            end else begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            // candidate overflow: no larger prime is representable
            if (cand_q == '1) begin
               state_d = ERR;
            end else begin
               cand_d  = cand_q + DATA_W'(1);
               div_d   = DATA_W'(2);
               state_d = CHECK;
            end
         end
         DONE: begin
            s_d        = ST_DONE;
            done_cnt_d = done_cnt_q + 16'd1;
            state_d    = IDLE;
         end
         ERR: begin
            s_d     = ST_ERR;
            w_d     = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // a write of A restarts from any state, overriding the step above
      if (wr_a) begin
         a_d     = sdata_in;
         w_d     = '0;
         found_d = '0;
         cand_d  = DATA_W'(2);
         div_d   = DATA_W'(2);
         s_d     = ST_BUSY;
         start_d = 1'b0;
         state_d = (sdata_in == '0) ? ERR : CHECK;
      end

      if (srd) begin
         sdata_d = '0;
         if (saddress == ADDR_W) begin
            sdata_d = w_q;
         end else if (saddress == ADDR_S) begin
            sdata_d = {{(DATA_W-2){1'b0}}, s_q};
         end
`ifdef GPIOEMU_PRIME_PROGRESS_EN
         else if (saddress == ADDR_P) begin
            sdata_d = found_q;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         w_q        <= '0;
         s_q        <= ST_IDLE;
         done_cnt_q <= '0;
         cand_q     <= '0;
         div_q      <= '0;
         found_q    <= '0;
         start_q    <= 1'b0;
         sdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         w_q        <= w_d;
         s_q        <= s_d;
         done_cnt_q <= done_cnt_d;
         cand_q     <= cand_d;
         div_q      <= div_d;
         found_q    <= found_d;
         start_q    <= start_d;
         sdata_q    <= sdata_d;
      end
   end

   assign sdata_out = sdata_q;
   assign gpio_out  = {16'h0000, done_cnt_q};
   assign busy      = (s_q == ST_BUSY);

endmodule

// File: tb/tb_gpioemu_prime_seq.sv
// tb/tb_gpioemu_prime_seq.sv - table-driven and sequence checks of gpioemu_prime_seq at DATA_W 32 and 8
module tb_gpioemu_prime_seq;

   localparam logic [15:0] ADDR_A = 16'h0224;
   localparam logic [15:0] ADDR_W = 16'h0234;
   localparam logic [15:0] ADDR_P = 16'h0238;
   localparam logic [15:0] ADDR_S = 16'h023C;
   localparam int          LIMIT  = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic [15:0] sa32 = '0;
   logic        rd32 = 1'b0, wr32 = 1'b0;
   logic [31:0] din32 = '0, dout32, gpio32;
   logic        busy32;

   logic [15:0] sa8 = '0;
   logic        rd8 = 1'b0, wr8 = 1'b0;
   logic [7:0]  din8 = '0, dout8;
   logic [31:0] gpio8;
   logic        busy8;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [31:0] a;
      logic [1:0]  s;
      logic [31:0] w;
   } vec_t;
   vec_t vecs[6];

   always #5 clk = ~clk;

   gpioemu_prime_seq #(.DATA_W(32)) u32 (
      .clk(clk), .reset(reset), .saddress(sa32), .srd(rd32), .swr(wr32),
      .sdata_in(din32), .sdata_out(dout32), .gpio_out(gpio32), .busy(busy32)
   );

   gpioemu_prime_seq #(.DATA_W(8)) u8 (
      .clk(clk), .reset(reset), .saddress(sa8), .srd(rd8), .swr(wr8),
      .sdata_in(din8), .sdata_out(dout8), .gpio_out(gpio8), .busy(busy8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wr32_t(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk); sa32 = a; din32 = d; wr32 = 1'b1;
      @(negedge clk); wr32 = 1'b0;
   endtask

   task automatic rd32_t(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk); sa32 = a; rd32 = 1'b1;
      @(negedge clk); rd32 = 1'b0; d = dout32;
   endtask

   task automatic wait32(output logic [1:0] s);
      int n;
      @(negedge clk); sa32 = ADDR_S; rd32 = 1'b1; n = 0;
      do begin @(negedge clk); n++; end while (dout32[1:0] == 2'd1 && n < LIMIT);
      rd32 = 1'b0; s = dout32[1:0];
      if (n >= LIMIT) check("wait32_timeout", n, 0);
   endtask

   task automatic wr8_t(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk); sa8 = a; din8 = d; wr8 = 1'b1;
      @(negedge clk); wr8 = 1'b0;
   endtask

   task automatic rd8_t(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk); sa8 = a; rd8 = 1'b1;
      @(negedge clk); rd8 = 1'b0; d = dout8;
   endtask

   task automatic wait8(output logic [1:0] s);
      int n;
      @(negedge clk); sa8 = ADDR_S; rd8 = 1'b1; n = 0;
      do begin @(negedge clk); n++; end while (dout8[1:0] == 2'd1 && n < LIMIT);
      rd8 = 1'b0; s = dout8[1:0];
      if (n >= LIMIT) check("wait8_timeout", n, 0);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  d8;
      logic [1:0]  s;
      logic [31:0] exp_cnt;
      logic [31:0] exp_p;
      int          n;

      vecs[0] = '{32'd1,  2'd2, 32'd2};
      vecs[1] = '{32'd5,  2'd2, 32'd11};
      vecs[2] = '{32'd0,  2'd3, 32'd0};
      vecs[3] = '{32'd2,  2'd2, 32'd3};
      vecs[4] = '{32'd7,  2'd2, 32'd17};
      vecs[5] = '{32'd12, 2'd2, 32'd37};
      exp_cnt = 0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_sdata_out", dout32, 0);
      check("rst_gpio_out", gpio32, 0);
      check("rst_busy", {31'd0, busy32}, 0);
      rd32_t(ADDR_S, d);
      check("rst_status", d, 0);

      // A=1 fixed latency: status read held continuously after the write edge
      @(negedge clk); sa32 = ADDR_A; din32 = 32'd1; wr32 = 1'b1;
      @(negedge clk); wr32 = 1'b0; sa32 = ADDR_S; rd32 = 1'b1; n = 0;
      check("a1_busy", {31'd0, busy32}, 1);
      do begin @(negedge clk); n++; end while (dout32[1:0] != 2'd2 && n < 20);
      rd32 = 1'b0;
      check("a1_latency", n, 4);
      exp_cnt++;
      rd32_t(ADDR_W, d);
      check("a1_w", d, 2);
      check("a1_gpio", gpio32, exp_cnt);

      for (int i = 0; i < 6; i++) begin
         wr32_t(ADDR_A, vecs[i].a);
         wait32(s);
         check($sformatf("vec%0d_status", i), {30'd0, s}, {30'd0, vecs[i].s});
         rd32_t(ADDR_W, d);
         check($sformatf("vec%0d_w", i), d, vecs[i].w);
         if (vecs[i].s == 2'd2) exp_cnt++;
         check($sformatf("vec%0d_gpio", i), gpio32, exp_cnt);
         check($sformatf("vec%0d_busy", i), {31'd0, busy32}, 0);
      end

`ifdef GPIOEMU_PRIME_PROGRESS_EN
      exp_p = 32'd12;
`else
      exp_p = 32'd0;
`endif
      rd32_t(ADDR_P, d);
      check("p_read", d, exp_p);
      rd32_t(16'h0000, d);
      check("unmapped_read", d, 0);
      wr32_t(ADDR_W, 32'hDEAD_BEEF);
      rd32_t(ADDR_W, d);
      check("ignored_write_w", d, 37);
      rd32_t(ADDR_S, d);
      check("ignored_write_s", d, 2);

      // restart-on-write: A=10 aborted by A=3
      wr32_t(ADDR_A, 32'd10);
      repeat (60) @(negedge clk);
      check("restart_busy", {31'd0, busy32}, 1);
      wr32_t(ADDR_A, 32'd3);
      wait32(s);
      check("restart_status", {30'd0, s}, 2);
      rd32_t(ADDR_W, d);
      check("restart_w", d, 5);
      exp_cnt++;
      check("restart_gpio", gpio32, exp_cnt);

      // 8-bit instance: largest representable prime, then candidate overflow
      wr8_t(ADDR_A, 8'd54);
      wait8(s);
      check("w8_a54_status", {30'd0, s}, 2);
      rd8_t(ADDR_W, d8);
      check("w8_a54_w", {24'd0, d8}, 251);
      check("w8_a54_gpio", gpio8, 1);
      wr8_t(ADDR_A, 8'd55);
      wait8(s);
      check("w8_a55_status", {30'd0, s}, 3);
      rd8_t(ADDR_W, d8);
      check("w8_a55_w", {24'd0, d8}, 0);
      check("w8_a55_gpio", gpio8, 1);

      // asynchronous reset in the middle of a long run
      wr32_t(ADDR_A, 32'd100);
      rd32_t(ADDR_S, d);
      check("midrun_status", d, 1);
      repeat (300) @(negedge clk);
      check("midrun_busy", {31'd0, busy32}, 1);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      check("async_sdata_out", dout32, 0);
      check("async_gpio", gpio32, 0);
      check("async_busy", {31'd0, busy32}, 0);
      @(negedge clk); reset = 1'b0;
      rd32_t(ADDR_S, d);
      check("post_reset_status", d, 0);
      rd32_t(ADDR_W, d);
      check("post_reset_w", d, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/gpioemu_prime_seq.md
# gpioemu_prime_seq

Parametrised successor to the GPIO-emulator N-th-prime peripheral. It sits on the same emulated system bus (saddress/srd/swr/sdata_in/sdata_out) and computes the A-th prime. Trial division runs on a multi-cycle sequential divider, so there is no combinational loop, and the data width is generic. New relative to the previous generation: single-clock bus sampling, restart-on-write, an error status for A=0 and candidate overflow, and a completion counter on gpio_out.

## Interface
- DATA_W, 32: width of A, W, candidate, divisor and sdata buses (range 8..32).
- ADDR_A, 16'h224: write address of A (prime index).
- ADDR_W, 16'h234: read address of W (result).
- ADDR_S, 16'h23C: read address of S (status).
- ADDR_P, 16'h238: read address of P (primes found so far); exists only when the Configuration macro is defined.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- saddress  in  16  bus address.
- srd  in  1  read strobe, level, sampled on clk.
- swr  in  1  write strobe, level, sampled on clk.
- sdata_in  in  DATA_W  write data.
- sdata_out  out  DATA_W  registered read data; reset 0.
- gpio_out  out  32  {16'h0, done_cnt[15:0]}; reset 0.
- busy  out  1  high while S==1; reset 0.

## Operation
- Registers: A, W, S (0 idle, 1 busy, 2 done, 3 error), done_cnt (16 bits), cand, div, found.
- FSM states: IDLE, CHECK, DIV_RUN, EVAL, NEXT, DONE, ERR.
- A write (swr=1, saddress==ADDR_A) latches A, clears W and found, sets cand=2, div=2 and S=1, then enters CHECK. This applies in any state: a write while busy aborts the current run and restarts it.
- If the latched A==0, go to ERR instead.
- CHECK: if div*div > cand (compare at 2*DATA_W width), cand is prime, go to EVAL. Otherwise pulse start to the divider and go to DIV_RUN.
- DIV_RUN: wait for divider done. If rem==0, cand is composite, go to NEXT. Otherwise div+=1 and go to CHECK.
- EVAL: found+=1. If found+1==A, W<=cand, go to DONE. Otherwise go to NEXT.
- NEXT: if cand == 2^DATA_W-1, go to ERR. Otherwise cand+=1, div=2, go to CHECK.
- DONE: S=2, done_cnt+=1 (wraps 16'hFFFF to 0), go to IDLE.
- ERR: S=3, W=0, done_cnt unchanged, go to IDLE.
- Reads (srd=1): sdata_out<=W / S / P according to saddress. Any other address returns 0. When srd=0, sdata_out holds its value.
- Writes to any address other than ADDR_A are ignored.

## Timing
- Read latency: 1 clk (data is valid on the edge after srd is sampled).
- A read in the same cycle as an A write returns the pre-write value. S shows 1 from the next cycle.
- Write to CHECK: 1 clk. Each trial division takes DATA_W+2 clk (start, DATA_W iterations, done). CHECK, EVAL and NEXT take 1 clk each.
- A=1 fixed latency: write edge, then CHECK (2*2>2, prime), EVAL, DONE. S=2 is visible 4 clk after the write edge.
- Reset asserted mid-run forces IDLE and sets all outputs to 0 immediately (asynchronous). The divider aborts.
- If srd and swr are both high, both are honoured.

## Configuration
- GPIOEMU_PRIME_PROGRESS_EN defined: the P register is readable at ADDR_P and returns found, updated live during a run.
- Not defined: ADDR_P decodes as an unmapped address and reads return 0. The found counter is still kept internally.

## Structure
- Shared package gpioemu_pkg holds:
  - the status codes (ST_IDLE=0, ST_BUSY=1, ST_DONE=2, ST_ERR=3);
  - the FSM state enum;
  - the default address constants.
- Sub-module prime_rem_div: sequential restoring divider, DATA_W-parametrised, with a start/done handshake. It outputs the remainder only, and done is a 1-clk pulse. It ignores start while running. Reset aborts it.

## Test plan
- Reset, then write A=1 and poll S: S=2 at write+4 clk, read W → 2, gpio_out → 32'h1.
- Write A=5 and wait for S=2: W → 11, busy low, gpio_out increments by 1.
- Write A=0: S → 3, W → 0, gpio_out unchanged. A following write of A=2 gives W=3.
- Write A=10, then write A=3 while busy: W → 5, gpio_out increments exactly once, and W is never 29.
- DATA_W=8, write A=54: W → 251. Then write A=55: S → 3 via the candidate-overflow path.
- Assert reset mid-run with A=100: sdata_out, gpio_out and busy go to 0 at once, and S reads 0 after reset is released.
